// File: rtl/md5_crack_ctrl.sv
// md5_crack_ctrl: walks a BCD range of 8-digit ASCII candidates through an md5 core and reports the first hash match
module md5_crack_ctrl #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  input  logic [31:0]      range_lo,
  input  logic [31:0]      range_hi,
  input  logic [127:0]     target_hash,
  output logic [63:0]      md5_msg,
  output logic             md5_start,
  input  logic             md5_done,
  input  logic [127:0]     md5_hash,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [63:0]      password,
  output logic [CNT_W-1:0] tries
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] cur, hi, inc;
  logic [127:0] tgt;
  logic match, inflight, valid, c;
  function automatic logic [63:0] to_ascii(input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i+:8] = {4'h3, b[4*i+:4]};
    return r;
  endfunction
  assign md5_start = state == S_ISSUE;
  assign busy = state != S_IDLE;
  // current candidate is recovered from the low nibbles of the message; BCD increment and range digit check
  always_comb begin
    cur = '0;
    inc = '0;
    valid = 1'b1;
    c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cur[4*i+:4] = md5_msg[8*i+:4];
      inc[4*i+:4] = c ? ((md5_msg[8*i+:4] == 4'd9) ? 4'd0 : md5_msg[8*i+:4] + 4'd1) : md5_msg[8*i+:4];
      c = c && (md5_msg[8*i+:4] == 4'd9);
      valid = valid && (range_lo[4*i+:4] <= 4'd9) && (range_hi[4*i+:4] <= 4'd9);
    end
  end
  // next-state logic; a match in S_NEXT beats a concurrent abort
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = (cmd_start && valid && range_lo <= range_hi) ? S_ISSUE : S_IDLE;
      S_ISSUE: state_n = cmd_abort ? S_DRAIN : S_WAIT;
      S_WAIT:  state_n = cmd_abort ? S_DRAIN : md5_done ? S_NEXT : S_WAIT;
      S_NEXT:  state_n = match ? S_IDLE : cmd_abort ? S_DRAIN : (cur == hi) ? S_IDLE : S_ISSUE;
      S_DRAIN: state_n = (!inflight || md5_done) ? S_IDLE : S_DRAIN;
      default: state_n = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_n;
  // datapath: candidate message, latched range/target, result flags and done pulse
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      md5_msg <= '0;
      hi <= '0;
      tgt <= '0;
      match <= 1'b0;
      inflight <= 1'b0;
      done <= 1'b0;
      found <= 1'b0;
      err <= 1'b0;
      password <= '0;
      tries <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (cmd_start) begin
          found <= 1'b0;
          err <= !valid;
          password <= '0;
          tries <= '0;
          done <= !valid || range_lo > range_hi;
          if (valid && range_lo <= range_hi) begin
            md5_msg <= to_ascii(range_lo);
            hi <= range_hi;
            tgt <= target_hash;
          end
        end
        S_ISSUE: inflight <= 1'b1;
        S_WAIT: if (md5_done) begin
          match <= md5_hash == tgt;
          tries <= tries + 1'b1;
          inflight <= 1'b0;
        end
        S_NEXT: if (match) begin
          password <= md5_msg;
          found <= 1'b1;
          done <= 1'b1;
        end else if (!cmd_abort) begin
          if (cur == hi) done <= 1'b1;
          else md5_msg <= to_ascii(inc);
        end
        S_DRAIN: if (!inflight || md5_done) done <= 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_md5_crack_ctrl.sv
// tb_md5_crack_ctrl: drives the cracker against a fake fixed-latency hash core and a decimal reference model
module tb_md5_crack_ctrl;
  localparam logic [63:0] REAL_MSG = 64'h3132333435363738;
  localparam logic [127:0] REAL_H = 128'h25d55ad283aa400af464c76d713c07ad;
  logic clk = 0, reset_n = 0, core_rn = 0, cmd_start = 0, cmd_abort = 0;
  logic md5_start, md5_done = 0, busy, done, found, err;
  logic [31:0] range_lo = 0, range_hi = 0;
  logic [127:0] target_hash = 0, md5_hash = 0;
  logic [63:0] md5_msg, password, cmsg = 0;
  logic [26:0] tries;
  int checks = 0, failures = 0, lat = 4, cyc = 0, cnt = 0, unstable = 0;
  logic [63:0] started[$];
  int st_cyc[$];

  md5_crack_ctrl #(.CNT_W(27)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .range_lo(range_lo), .range_hi(range_hi), .target_hash(target_hash),
    .md5_msg(md5_msg), .md5_start(md5_start), .md5_done(md5_done), .md5_hash(md5_hash),
    .busy(busy), .done(done), .found(found), .err(err), .password(password), .tries(tries)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] fake(input logic [63:0] m);
    return (m == REAL_MSG) ? REAL_H : {m ^ 64'h5a5a_c3c3_0f0f_9696, ~{m[31:0], m[63:32]}};
  endfunction

  function automatic logic [63:0] dec_ascii(input int v);
    logic [63:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[8*i+:8] = 8'(8'h30 + x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input int v);
    logic [31:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // fake core: latches the message on start, answers lat+1 edges later
  always @(posedge clk or negedge core_rn)
    if (!core_rn) begin
      cnt <= 0;
      md5_done <= 0;
    end else begin
      md5_done <= 0;
      if (cnt != 0 && md5_msg !== cmsg) unstable <= unstable + 1;
      if (md5_start) begin
        cnt <= lat;
        cmsg <= md5_msg;
        started.push_back(md5_msg);
        st_cyc.push_back(cyc);
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          md5_done <= 1;
          md5_hash <= fake(cmsg);
        end
      end
    end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [31:0] lo, input logic [31:0] hi, input logic [127:0] t);
    @(negedge clk);
    range_lo = lo;
    range_hi = hi;
    target_hash = t;
    cmd_start = 1;
    @(negedge clk);
    cmd_start = 0;
  endtask

  task automatic wait_done(output bit ok, output int n, output bit mprev);
    ok = 0;
    n = 0;
    mprev = 0;
    while (n < 4000) begin
      n++;
      if (done) begin
        ok = 1;
        break;
      end
      mprev = md5_done;
      @(negedge clk);
    end
  endtask

  task automatic search(input int lo_i, input int hi_i, input logic [127:0] t, input string tag);
    logic [63:0] exp_q[$];
    logic [63:0] m, ep;
    bit ok, mp, ef;
    int n, base, ub, gb;
    base = started.size();
    ub = unstable;
    ef = 0;
    ep = '0;
    for (int v = lo_i; v <= hi_i; v++) begin
      m = dec_ascii(v);
      exp_q.push_back(m);
      if (fake(m) == t) begin
        ef = 1;
        ep = m;
        break;
      end
    end
    start_cmd(int2bcd(lo_i), int2bcd(hi_i), t);
    wait_done(ok, n, mp);
    chk({tag, "_done"}, 128'(ok), 1);
    chk({tag, "_found"}, 128'(found), 128'(ef));
    chk({tag, "_password"}, password, ep);
    chk({tag, "_tries"}, tries, exp_q.size());
    chk({tag, "_err"}, err, 0);
    chk({tag, "_nstarts"}, started.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < started.size(); i++)
      chk({tag, "_msg"}, started[base+i], exp_q[i]);
    gb = 0;
    for (int i = base + 1; i < st_cyc.size(); i++)
      if (st_cyc[i] - st_cyc[i-1] != lat + 3) gb++;
    chk({tag, "_start_gap"}, gb, 0);
    chk({tag, "_msg_stable"}, unstable - ub, 0);
    @(negedge clk);
    chk({tag, "_done_width"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    bit ok, mp;
    int n, base, lo_i, span;
    logic [127:0] t;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", md5_start, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_err", err, 0);
    chk("rst_password", password, 0);
    chk("rst_tries", tries, 0);
    chk("rst_msg", md5_msg, 0);
    reset_n = 1;
    core_rn = 1;
    search(12345670, 12345679, REAL_H, "real");
    chk("real_password_lit", password, 64'h3132333435363738);
    search(0, 3, 0, "miss4");
    search(99, 101, 0, "carry");
    base = started.size();
    start_cmd(32'h0000000A, 32'h00000012, 0);
    wait_done(ok, n, mp);
    chk("bad_done_next_cycle", n, 1);
    chk("bad_err", err, 1);
    chk("bad_found", found, 0);
    chk("bad_tries", tries, 0);
    chk("bad_no_start", started.size() - base, 0);
    search(5, 2, 0, "inverted");
    for (int k = 0; k < 6; k++) begin
      lat = $urandom_range(2, 7);
      lo_i = $urandom_range(0, 99999990);
      span = $urandom_range(0, 4);
      t = $urandom_range(0, 1) ? fake(dec_ascii(lo_i + $urandom_range(0, span))) : 128'h0;
      search(lo_i, lo_i + span, t, "rand");
    end
    lat = 6;
    base = started.size();
    start_cmd(int2bcd(0), int2bcd(9), 0);
    n = 0;
    while (started.size() < base + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_second_start", started.size() - base, 2);
    @(negedge clk);
    cmd_abort = 1;
    @(negedge clk);
    cmd_abort = 0;
    cmd_start = 1;
    @(negedge clk);
    cmd_start = 0;
    wait_done(ok, n, mp);
    chk("abort_done", 128'(ok), 1);
    chk("abort_done_after_core", 128'(mp), 1);
    chk("abort_found", found, 0);
    chk("abort_tries", tries, 1);
    chk("abort_no_new_start", started.size() - base, 2);
    repeat (10) @(negedge clk);
    chk("abort_start_ignored", started.size() - base, 2);
    chk("abort_idle", busy, 0);
    lat = 10;
    base = started.size();
    start_cmd(int2bcd(0), int2bcd(9), 0);
    n = 0;
    while (started.size() < base + 1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("areset_in_wait", busy, 1);
    #2;
    reset_n = 0;
    core_rn = 0;
    #1;
    chk("areset_busy", busy, 0);
    chk("areset_start", md5_start, 0);
    chk("areset_done", done, 0);
    chk("areset_msg", md5_msg, 0);
    @(negedge clk);
    reset_n = 1;
    core_rn = 1;
    lat = 4;
    search(12345678, 12345678, REAL_H, "after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/md5_crack_ctrl.md
Name: md5_crack_ctrl

Overview:
- Search controller that drives one md5 hash core through a range of 8-digit decimal ASCII candidates and reports the first candidate whose hash equals a target.
- It is the initiator side of the core's start/done handshake. It builds each message, pulses start, waits for done, compares the hash, then advances with a BCD increment.
- Sits between the command/UART layer and the md5 core in the password-cracking datapath.

Parameters:
- CNT_W, 27, width of tries counter (must hold 10^8).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- cmd_start  input  1  one-cycle pulse; begin search (accepted only in S_IDLE)
- cmd_abort  input  1  one-cycle pulse; stop search
- range_lo  input  32  first candidate, 8 BCD digits, nibble [31:28] = leftmost character
- range_hi  input  32  last candidate, BCD, inclusive
- target_hash  input  128  expected hash, bit-for-bit same ordering as md5_hash
- md5_msg  output  64  candidate ASCII; byte [63:56] = first character
- md5_start  output  1  start pulse to core
- md5_done  input  1  core done pulse; md5_hash valid in that cycle
- md5_hash  input  128  core hash output
- busy  output  1  high in any state other than S_IDLE
- done  output  1  one-cycle pulse at search end
- found  output  1  held; last search matched
- err  output  1  held; last command had an invalid range
- password  output  64  held; matching candidate ASCII, 0 if none
- tries  output  CNT_W  held; hashes completed in last/current search

Behaviour:
- Reset (async, any state): state = S_IDLE. md5_start, done, found, err, busy are 0. password, tries and md5_msg are 0.
- Candidate encoding: character i = 8'h30 + BCD nibble i.
- S_IDLE, on cmd_start:
  - Clear found, err, password and tries.
  - If any nibble of range_lo or range_hi is > 9: set err = 1, pulse done, stay in S_IDLE.
  - Else if range_lo > range_hi (unsigned compare of the 32-bit BCD): pulse done, found = 0, stay in S_IDLE.
  - Else: cur ← range_lo, latch range_hi and target_hash, go to S_ISSUE.
  - cmd_abort in S_IDLE is ignored.
- S_ISSUE:
  - md5_start = 1 for exactly this cycle; md5_msg = ASCII(cur).
  - md5_msg stays stable from this cycle until md5_done.
  - Go to S_WAIT.
- S_WAIT:
  - Hold until md5_done. There is no timeout.
  - On the md5_done cycle: register match = (md5_hash == target) and tries ← tries + 1.
  - Go to S_NEXT.
- S_NEXT:
  - If match: password ← ASCII(cur), found = 1, pulse done, go to S_IDLE.
  - Else if cur == range_hi: found = 0, pulse done, go to S_IDLE.
  - Else: cur ← BCD increment of cur (digit 9 → 0 with carry into the next-left digit), go to S_ISSUE.
  - 99999999 never increments, because range_hi ≤ 99999999 terminates first.
- cmd_abort:
  - In S_ISSUE, S_NEXT, or S_WAIT with no md5_done that cycle: go to S_DRAIN.
  - In S_WAIT on the same cycle as md5_done: the result is still evaluated, then go to S_DRAIN.
  - In S_ISSUE the start pulse still issues; the core cannot be cancelled.
- S_DRAIN:
  - Entered with a hash in flight: wait for md5_done, discard its result, do not count it, then pulse done with found = 0 and go to S_IDLE.
  - Entered from S_NEXT (no hash in flight): finish in the next cycle.
- Abort that coincides with a match in S_NEXT: the match wins (found = 1).
- cmd_start while busy is ignored.
- md5_done outside S_WAIT/S_DRAIN is ignored.
- Throughput: one candidate per (core latency + 2) cycles. With the 67-cycle core, start-to-start is 69 cycles.
- done is a registered pulse exactly 1 cycle wide. found, password, tries and err hold until the next accepted cmd_start.

Test Plan:
- range 12345670..12345679, target 25d55ad283aa400af464c76d713c07ad (MD5 "12345678") → done pulse, found = 1, password = 64'h3132333435363738, tries = 9.
- range 00000000..00000003, unreachable target → four start pulses with md5_msg = "00000000".."00000003"; done, found = 0, tries = 4, password = 0.
- range 00000099..00000101 → md5_msg sequence "00000099", "00000100", "00000101" (carry ripple); tries = 3.
- range_lo = 0000000A → done in the cycle after cmd_start, err = 1, md5_start never asserted. Separately, range_lo = 00000005, range_hi = 00000002 → done, err = 0, tries = 0.
- cmd_abort during S_WAIT of the second candidate → no new md5_start after md5_done; done follows md5_done by 1 cycle; found = 0, tries = 1. cmd_start during the drain is ignored.
- reset_n low mid-S_WAIT, asynchronous → busy, md5_start and done drop immediately; after release, a fresh search on 12345678..12345678 finds it with tries = 1 (the bench also resets the core).
